// File: rtl/payload_crc_checker.sv
// Byte-serial payload/CRC checker: runtime payload length, MSB-first byte-wise CRC,
// per-packet result pulses and saturating good/bad packet counters.
module payload_crc_checker #(
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned CRC_BYTES = 1,
  parameter logic [31:0] CRC_POLY  = 32'h07,
  parameter logic [31:0] CRC_INIT  = 32'h00,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic [LEN_W-1:0] payload_len,
  output logic             busy,
  output logic             packet_done,
  output logic             packet_valid,
  output logic             crc_err,
  output logic             packet_abort,
  output logic [CNT_W-1:0] valid_packet_counter,
  output logic [CNT_W-1:0] error_packet_counter
);

  localparam int unsigned CRC_W = 8 * CRC_BYTES;
  localparam logic [CRC_W-1:0] Poly = CRC_POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] Init = CRC_INIT[CRC_W-1:0];
  localparam logic [1:0] LastCrc = 2'(CRC_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StPayload, StCrc} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pay_cnt_q;
  logic [1:0]       crc_cnt_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] rx_crc_q;

  logic             accept;
  logic             abort_now;
  logic             last_crc;
  logic             match;
  logic [CRC_W-1:0] crc_calc;
  logic [CRC_W+7:0] rx_cat;
  logic [CRC_W-1:0] rx_next;
  logic [LEN_W-1:0] pay_cnt_next;

  assign accept       = enable & data_valid;
  assign abort_now    = ~enable & (state_q != StIdle);
  assign rx_cat       = {rx_crc_q, data_in};
  assign rx_next      = rx_cat[CRC_W-1:0];
  assign match        = (rx_next == crc_q);
  assign pay_cnt_next = pay_cnt_q + LEN_W'(1);

  // A zero-length packet with a 1-byte CRC completes on its very first byte.
  assign last_crc = accept &&
                    (((state_q == StCrc) && (crc_cnt_q == LastCrc)) ||
                     ((state_q == StIdle) && (payload_len == '0) && (CRC_BYTES == 1)));

  always_comb begin
    crc_calc = crc_q ^ (CRC_W'(data_in) << (CRC_W - 8));
    for (int i = 0; i < 8; i++) begin
      crc_calc = crc_calc[CRC_W-1] ? ((crc_calc << 1) ^ Poly) : (crc_calc << 1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= StIdle;
      len_q                <= '0;
      pay_cnt_q            <= '0;
      crc_cnt_q            <= '0;
      crc_q                <= Init;
      rx_crc_q             <= '0;
      busy                 <= 1'b0;
      packet_done          <= 1'b0;
      packet_valid         <= 1'b0;
      crc_err              <= 1'b0;
      packet_abort         <= 1'b0;
      valid_packet_counter <= '0;
      error_packet_counter <= '0;
    end else begin
      packet_done  <= 1'b0;
      packet_valid <= 1'b0;
      crc_err      <= 1'b0;
      packet_abort <= 1'b0;
      if (abort_now) begin
        state_q      <= StIdle;
        busy         <= 1'b0;
        packet_abort <= 1'b1;
        crc_q        <= Init;
      end else if (last_crc) begin
        state_q     <= StIdle;
        busy        <= 1'b0;
        packet_done <= 1'b1;
        crc_q       <= Init;
        rx_crc_q    <= rx_next;
        if (match) begin
          packet_valid <= 1'b1;
          if (valid_packet_counter != '1) valid_packet_counter <= valid_packet_counter + 1'b1;
        end else begin
          crc_err <= 1'b1;
          if (error_packet_counter != '1) error_packet_counter <= error_packet_counter + 1'b1;
        end
      end else if (accept) begin
        unique case (state_q)
          StIdle: begin
            busy  <= 1'b1;
            len_q <= payload_len;
            if (payload_len == '0) begin
              rx_crc_q  <= rx_next;
              crc_cnt_q <= 2'd1;
              state_q   <= StCrc;
            end else begin
              crc_q     <= crc_calc;
              pay_cnt_q <= LEN_W'(1);
              crc_cnt_q <= 2'd0;
              state_q   <= (payload_len == LEN_W'(1)) ? StCrc : StPayload;
            end
          end
          StPayload: begin
            crc_q     <= crc_calc;
            pay_cnt_q <= pay_cnt_next;
            if (pay_cnt_next == len_q) state_q <= StCrc;
          end
          StCrc: begin
            rx_crc_q  <= rx_next;
            crc_cnt_q <= crc_cnt_q + 2'd1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_payload_crc_checker.sv
// Scoreboard bench for payload_crc_checker: stimulus pushes expected packet events,
// a negedge monitor pops and compares whenever a result or abort pulse appears.
module tb_payload_crc_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [5:0] payload_len = 6'd0;
  logic       busy, packet_done, packet_valid, crc_err, packet_abort;
  logic [3:0] valid_packet_counter, error_packet_counter;

  payload_crc_checker dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .enable               (enable),
    .data_valid           (data_valid),
    .data_in              (data_in),
    .payload_len          (payload_len),
    .busy                 (busy),
    .packet_done          (packet_done),
    .packet_valid         (packet_valid),
    .crc_err              (crc_err),
    .packet_abort         (packet_abort),
    .valid_packet_counter (valid_packet_counter),
    .error_packet_counter (error_packet_counter)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       done;
    logic       valid;
    logic       err;
    logic       abort;
    logic [3:0] vcnt;
    logic [3:0] ecnt;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  model_v = 0;
  int  model_e = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every result/abort pulse must match the oldest expected event.
  always @(negedge clock) begin
    if (reset_n && (packet_done || packet_valid || crc_err || packet_abort)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {packet_done, packet_valid, crc_err, packet_abort}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("done", packet_done, e.done);
        check("valid", packet_valid, e.valid);
        check("crc_err", crc_err, e.err);
        check("abort", packet_abort, e.abort);
        check("valid_cnt", valid_packet_counter, e.vcnt);
        check("error_cnt", error_packet_counter, e.ecnt);
      end
    end
  end

  task automatic put(input logic [7:0] b);
    data_valid = 1'b1;
    data_in    = b;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_result(input bit good);
    ev_t e;
    if (good && model_v < 15) model_v++;
    if (!good && model_e < 15) model_e++;
    e = '{done: 1'b1, valid: good, err: !good, abort: 1'b0,
          vcnt: 4'(model_v), ecnt: 4'(model_e)};
    exp_q.push_back(e);
  endtask

  // Payload bytes are 0x31.. ("123456789" for len 9); gapmax>0 inserts 1..gapmax stall cycles.
  task automatic send_pkt(input int len, input logic [7:0] crcb, input int gapmax, input bit good);
    payload_len = 6'(len);
    for (int i = 0; i < len; i++) begin
      if (gapmax > 0) stall($urandom_range(gapmax, 1));
      put(8'h31 + 8'(i));
    end
    if (gapmax > 0) stall($urandom_range(gapmax, 1));
    push_result(good);
    put(crcb);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_pulses", {packet_done, packet_valid, crc_err, packet_abort}, 0);
    check("rst_vcnt", valid_packet_counter, 0);
    check("rst_ecnt", error_packet_counter, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    stall(2);

    // 1: good packet, CRC-8 of "123456789" is 0xF4
    payload_len = 6'd9;
    put(8'h31);
    check("busy_after_first", busy, 1);
    for (int i = 1; i < 9; i++) put(8'h31 + 8'(i));
    push_result(1'b1);
    put(8'hF4);
    drain("t1");
    check("t1_busy_low", busy, 0);

    // 2: corrupted CRC byte
    send_pkt(9, 8'hF5, 0, 1'b0);
    drain("t2");

    // 3: stalls between every byte
    send_pkt(9, 8'hF4, 3, 1'b1);
    drain("t3");

    // 4: enable dropped after 5 payload bytes, then a good packet
    payload_len = 6'd9;
    for (int i = 0; i < 5; i++) put(8'h31 + 8'(i));
    check("t4_busy", busy, 1);
    exp_q.push_back('{done: 1'b0, valid: 1'b0, err: 1'b0, abort: 1'b1,
                      vcnt: 4'(model_v), ecnt: 4'(model_e)});
    enable = 1'b0;
    stall(1);
    drain("t4_abort");
    check("t4_busy_low", busy, 0);
    stall(2);
    enable = 1'b1;
    send_pkt(9, 8'hF4, 0, 1'b1);
    drain("t4");

    // 5: zero-length packet, then 16 back-to-back good packets to saturate
    send_pkt(0, 8'h00, 0, 1'b1);
    for (int k = 0; k < 16; k++) send_pkt(9, 8'hF4, 0, 1'b1);
    drain("t5");
    check("t5_sat", valid_packet_counter, 15);

    // 6: async reset mid-payload
    payload_len = 6'd9;
    for (int i = 0; i < 4; i++) put(8'h31 + 8'(i));
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    model_v = 0;
    model_e = 0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_vcnt", valid_packet_counter, 0);
    check("t6_ecnt", error_packet_counter, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    stall(2);
    send_pkt(9, 8'hF4, 0, 1'b1);
    drain("t6");
    stall(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
